param_dual_port_sram: RTL
=========================

Name: param_dual_port_sram

Overview:
Parametrised simple-dual-port SRAM: one write port and one independent read port on a single clock. Adds per-byte write enables, selectable 1- or 2-cycle registered read latency, and a defined read-during-write collision mode. A hardware clear sequencer zeroes the whole array on request. It is the generic on-chip storage block for buffers and register files, and replaces fixed 8-bit single-port storage.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of 8 (>= 8)
ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH words
READ_LATENCY, 1, 1 = data registered at the sampling edge; 2 = one extra output pipeline register
RDW_MODE, 0, same-address read/write in one cycle: 0 = read-first (old data), 1 = write-first (new data)

Ports:
Clk_In  input  1  clock; all logic on the rising edge
Reset_N_In  input  1  asynchronous, active-low reset
Write_Enable_In  input  1  write request, sampled each rising edge
Write_Address_In  input  ADDR_WIDTH  write address
Write_Data_In  input  DATA_WIDTH  write data
Byte_Enable_In  input  DATA_WIDTH/8  bit i enables byte i (bits 8i+7:8i) of the write
Read_Enable_In  input  1  read request, sampled each rising edge
Read_Address_In  input  ADDR_WIDTH  read address
Read_Data_Out  output  DATA_WIDTH  registered read data
Read_Valid_Out  output  1  single-cycle pulse marking new Read_Data_Out
Clear_In  input  1  request to start a full-array zero sweep
Busy_Out  output  1  high while the clear sweep is running

Behaviour:
- Reset is asynchronous, active-low: Read_Data_Out=0, Read_Valid_Out=0, Busy_Out=0, FSM=IDLE, clear counter=0, pipeline valid bits=0. Memory contents are not reset.
- Outputs are never driven to Z. Read_Data_Out holds its last value when there is no valid read.
- FSM has two states, IDLE and CLEAR.
- IDLE -> CLEAR on an edge with Clear_In=1. Busy_Out=1 from that edge. Write/read requests on that same edge are dropped.
- CLEAR: one word is zeroed per cycle at counter addresses 0..DEPTH-1, taking DEPTH cycles. The edge that writes DEPTH-1 returns the FSM to IDLE with Busy_Out=0 and resets the counter to 0.
- While Busy_Out=1, Write_Enable_In, Read_Enable_In and Clear_In are ignored: no memory write, no Read_Valid_Out.
- Write, IDLE only: at an edge with Write_Enable_In=1, byte i of mem[Write_Address_In] takes byte i of Write_Data_In where Byte_Enable_In[i]=1; other bytes are unchanged. All-zero Byte_Enable_In is a legal no-op.
- Read, IDLE only: request sampled at edge k.
  - READ_LATENCY=1: Read_Data_Out and Read_Valid_Out update at edge k.
  - READ_LATENCY=2: they update at edge k+1.
  - Read_Valid_Out is high for exactly one cycle per accepted read.
  - Back-to-back reads on consecutive edges give consecutive valid pulses, one read per cycle throughput.
- Collision (read and write at the same address on the same edge):
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the merged word: new bytes where the enable is set, old bytes elsewhere.
  - Different addresses do not interact.
- Reads at the old address after a write see the new data from the next edge onward, in both modes.
- Reset asserted mid-sweep aborts the sweep with Busy_Out=0 immediately. Partially cleared memory keeps its contents; no further sweep runs until a new Clear_In.
- Reset asserted mid-read flushes the pipeline; the pending Read_Valid_Out is never emitted.
- Address wrap is not possible because DEPTH = 2**ADDR_WIDTH; every address is valid.
- Elaboration must fail (generate-time error) if DATA_WIDTH%8!=0 or READ_LATENCY is not in {1,2}.

Test Plan:
- Basic write/read (DATA_WIDTH=16, LAT=1): write 0xA55A to addr 0x10 with BE=2'b11, then read addr 0x10 -> Read_Data_Out=0xA55A with Read_Valid_Out high for one cycle at the sampling edge; READ_LATENCY=2 build -> same data one edge later.
- Byte enables: write 0x1234 to addr 3, then write 0xFFEE with BE=2'b01, read addr 3 -> 0x12EE; BE=2'b00 write leaves 0x12EE.
- Collision: addr 5 holds 0x0001; same edge write 0xBEEF (BE=11) and read addr 5 -> RDW_MODE=0 returns 0x0001, RDW_MODE=1 returns 0xBEEF; subsequent read returns 0xBEEF in both.
- Clear sweep (ADDR_WIDTH=4): fill all 16 words nonzero, pulse Clear_In -> Busy_Out high exactly 16 cycles; writes/reads issued during Busy produce no effect and no Read_Valid_Out; afterwards every read returns 0.
- Reset mid-operation: assert Reset_N_In low during cycle 5 of a sweep and with a LAT=2 read in flight -> Busy_Out, Read_Valid_Out, Read_Data_Out go 0 asynchronously; words 0..4 read 0 afterwards, words 5..15 keep old values.
- Throughput: 8 consecutive reads of addrs 0..7 -> 8 consecutive Read_Valid_Out cycles with matching data in order.

Source files
------------

// File: rtl/param_dual_port_sram.sv
// Simple-dual-port SRAM with one write port and one read port on a single clock.
// - Writes use per-byte enables.
// - Read latency is 1 or 2 cycles.
// - Read-during-write to the same address is selectable (old data or merged new data).
// - A clear sequencer zeroes one word per cycle while Busy_Out is high.
module param_dual_port_sram #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic                    Clk_In,
    input  logic                    Reset_N_In,
    input  logic                    Write_Enable_In,
    input  logic [ADDR_WIDTH-1:0]   Write_Address_In,
    input  logic [DATA_WIDTH-1:0]   Write_Data_In,
    input  logic [DATA_WIDTH/8-1:0] Byte_Enable_In,
    input  logic                    Read_Enable_In,
    input  logic [ADDR_WIDTH-1:0]   Read_Address_In,
    output logic [DATA_WIDTH-1:0]   Read_Data_Out,
    output logic                    Read_Valid_Out,
    input  logic                    Clear_In,
    output logic                    Busy_Out
);

    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    // Reject word widths that are not whole bytes, and unsupported latencies.
    generate
        if (((DATA_WIDTH % 8) != 0) || (DATA_WIDTH < 8)) begin : g_bad_width
            $error("param_dual_port_sram: DATA_WIDTH must be a positive multiple of 8");
        end
        if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
            $error("param_dual_port_sram: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    rd_valid1_q, rd_valid1_d;

    logic                    accept;
    logic                    wr_go;
    logic                    rd_go;
    logic                    sweep_we;
    logic                    collide;
    logic [DATA_WIDTH-1:0]   rd_word;

    // Requests are honoured only in IDLE. On the edge that starts a sweep,
    // any request on that same edge is dropped.
    assign accept   = (state_q == ST_IDLE) && !Clear_In;
    assign wr_go    = accept && Write_Enable_In;
    assign rd_go    = accept && Read_Enable_In;
    assign sweep_we = (state_q == ST_CLEAR);
    assign collide  = wr_go && rd_go && (Write_Address_In == Read_Address_In);
    assign Busy_Out = (state_q == ST_CLEAR);

    // Next-state logic for the clear sweep. The counter walks 0..DEPTH-1,
    // then wraps to 0 as the FSM returns to IDLE.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rd_valid1_d = rd_go;
        case (state_q)
            ST_IDLE: begin
                if (Clear_In) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Control registers. Reset aborts any running sweep and flushes the
    // first read stage.
    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q     <= ST_IDLE;
            clr_cnt_q   <= '0;
            rd_valid1_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rd_valid1_q <= rd_valid1_d;
        end
    end

    // Each byte lane is its own RAM.
    // - A byte-enable becomes the lane's plain write enable.
    // - The sweep drives the lane's write port with zeros.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
            logic [7:0]            mem [DEPTH];
            logic                  lane_we;
            logic [ADDR_WIDTH-1:0] lane_addr;
            logic [7:0]            lane_wdata;
            logic [7:0]            wr_byte;
            logic [7:0]            rd_byte_q;

            assign wr_byte = Write_Data_In[gi*8 +: 8];

            // Select the lane write source: the sweep has priority, then byte-enabled user writes.
            always_comb begin
                lane_we    = 1'b0;
                lane_addr  = Write_Address_In;
                lane_wdata = wr_byte;
                if (sweep_we) begin
                    lane_we    = 1'b1;
                    lane_addr  = clr_cnt_q;
                    lane_wdata = 8'h00;
                end else if (wr_go && Byte_Enable_In[gi]) begin
                    lane_we = 1'b1;
                end
            end

            // Storage array; contents are not reset.
            always_ff @(posedge Clk_In) begin
                if (lane_we) begin
                    mem[lane_addr] <= lane_wdata;
                end
            end

            // Registered read. The nonblocking array read naturally returns old data.
            // Write-first mode bypasses the incoming byte on an enabled collision.
            always_ff @(posedge Clk_In or negedge Reset_N_In) begin
                if (!Reset_N_In) begin
                    rd_byte_q <= 8'h00;
                end else if (rd_go) begin
                    if ((RDW_MODE == 1) && collide && Byte_Enable_In[gi]) begin
                        rd_byte_q <= wr_byte;
                    end else begin
                        rd_byte_q <= mem[Read_Address_In];
                    end
                end
            end

            assign rd_word[gi*8 +: 8] = rd_byte_q;
        end
    endgenerate

    // Output stage. Latency 2 adds one register that loads only on a valid
    // read, so the data output holds between reads.
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
            logic                  out_valid_q, out_valid_d;

            // Advance the second pipeline stage.
            always_comb begin
                out_data_d  = out_data_q;
                out_valid_d = rd_valid1_q;
                if (rd_valid1_q) begin
                    out_data_d = rd_word;
                end
            end

            // Second-stage registers, flushed by reset.
            always_ff @(posedge Clk_In or negedge Reset_N_In) begin
                if (!Reset_N_In) begin
                    out_data_q  <= '0;
                    out_valid_q <= 1'b0;
                end else begin
                    out_data_q  <= out_data_d;
                    out_valid_q <= out_valid_d;
                end
            end

            assign Read_Data_Out  = out_data_q;
            assign Read_Valid_Out = out_valid_q;
        end else begin : g_lat1
            assign Read_Data_Out  = rd_word;
            assign Read_Valid_Out = rd_valid1_q;
        end
    endgenerate

endmodule
